// File: rtl/instruction_sequencer_if.sv
// -----------------------------------------------------------------------------
// instruction_sequencer_if
// Opcode handshake between the fetch stage and the instruction sequencer.
//   OpValid : fetch -> sequencer, an opcode is offered
//   OpCode  : fetch -> sequencer, 4-bit opcode, stable while OpValid && !OpReady
//   OpReady : sequencer -> fetch, the sequencer can take an opcode this cycle
// The opcode is transferred on a rising edge where OpValid && OpReady.
// -----------------------------------------------------------------------------
interface instruction_sequencer_if;
  logic       OpValid;
  logic [3:0] OpCode;
  logic       OpReady;

  modport master (output OpValid, output OpCode, input  OpReady);
  modport slave  (input  OpValid, input  OpCode, output OpReady);
endinterface

// File: rtl/instruction_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_sequencer
// Turns opcodes from the fetch stage into timed, registered one-hot enables
// for the 14 datapath units. One instruction is in flight at a time: short
// opcodes run for one cycle, long opcodes for LONG_CYCLES cycles, and the halt
// opcode parks the sequencer until Resume.
// Ports:
//   Clock      : rising-edge clock
//   Reset_n    : asynchronous active-low reset
//   op         : opcode handshake (OpValid / OpCode / OpReady)
//   Resume     : leave HALT (ignored in any other state)
//   F          : registered one-hot datapath enables, zero when idle
//   Done       : high in the final cycle of each retiring instruction
//   Illegal    : one-cycle pulse after an undefined opcode is accepted
//   Halted     : high while in HALT
//   InstrCount : retired-instruction counter, wraps
// -----------------------------------------------------------------------------
module instruction_sequencer #(
  parameter int LONG_CYCLES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  instruction_sequencer_if.slave   op,
  input  logic                     Resume,
  output logic [13:0]              F,
  output logic                     Done,
  output logic                     Illegal,
  output logic                     Halted,
  output logic [CNT_WIDTH-1:0]     InstrCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HALT = 2'd2
  } state_t;

  // remain counts down to zero; the cycle where it is zero is the last one
  localparam logic [3:0]           LONG_REMAIN = 4'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1'b1);

  // Opcode to one-hot enable; zero marks an undefined opcode
  function automatic logic [13:0] decode_onehot(input logic [3:0] code);
    logic [13:0] onehot;
    case (code)
      4'h0:    onehot = 14'h0001;
      4'h1:    onehot = 14'h0002;
      4'h2:    onehot = 14'h0004;
      4'h3:    onehot = 14'h0008;
      4'h4:    onehot = 14'h0010;
      4'h5:    onehot = 14'h0020;
      4'h6:    onehot = 14'h0040;
      4'h7:    onehot = 14'h0080;
      4'h8:    onehot = 14'h0100;
      4'hA:    onehot = 14'h0200;
      4'hB:    onehot = 14'h0400;
      4'hC:    onehot = 14'h0800;
      4'hD:    onehot = 14'h1000;
      4'hF:    onehot = 14'h2000;
      default: onehot = 14'h0000;
    endcase
    return onehot;
  endfunction

  // Opcodes that run for LONG_CYCLES instead of one cycle
  function automatic logic is_long(input logic [3:0] code);
    logic long_op;
    case (code)
      4'h8, 4'hA, 4'hB, 4'hC, 4'hD: long_op = 1'b1;
      default:                      long_op = 1'b0;
    endcase
    return long_op;
  endfunction

  state_t                 state_r, state_next_s;
  logic [13:0]            f_r, f_next_s;
  logic [3:0]             remain_r, remain_next_s;
  logic                   illegal_r, illegal_next_s;
  logic [CNT_WIDTH-1:0]   cnt_r, cnt_next_s;
  logic                   done_s;
  logic                   accept_s;
  logic [13:0]            decoded_s;

  assign accept_s  = op.OpValid && (state_r == IDLE);
  assign decoded_s = decode_onehot(op.OpCode);

  // State and datapath registers
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= IDLE;
      f_r       <= 14'h0000;
      remain_r  <= 4'h0;
      illegal_r <= 1'b0;
      cnt_r     <= '0;
    end else begin
      state_r   <= state_next_s;
      f_r       <= f_next_s;
      remain_r  <= remain_next_s;
      illegal_r <= illegal_next_s;
      cnt_r     <= cnt_next_s;
    end
  end

  // Next-state decision
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (op.OpCode == 4'hF) begin
            state_next_s = HALT;
          end else if (decoded_s != 14'h0000) begin
            state_next_s = EXEC;
          end else begin
            state_next_s = IDLE;   // illegal opcode: stay ready
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: begin
        if (remain_r == 4'h0) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = EXEC;
        end
      end
      HALT: begin
        if (Resume) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HALT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Enables, countdown, illegal flag, retire counter and Done
  always_comb begin
    f_next_s       = f_r;
    remain_next_s  = remain_r;
    illegal_next_s = 1'b0;
    cnt_next_s     = cnt_r;
    done_s         = 1'b0;
    case (state_r)
      IDLE: begin
        f_next_s      = 14'h0000;
        remain_next_s = 4'h0;
        if (accept_s) begin
          if (decoded_s == 14'h0000) begin
            illegal_next_s = 1'b1;
          end else begin
            f_next_s      = decoded_s;
            remain_next_s = is_long(op.OpCode) ? LONG_REMAIN : 4'h0;
          end
        end else begin
          illegal_next_s = 1'b0;
        end
      end
      EXEC: begin
        if (remain_r != 4'h0) begin
          remain_next_s = remain_r - 4'h1;
        end else begin
          done_s     = 1'b1;
          f_next_s   = 14'h0000;
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      HALT: begin
        if (Resume) begin
          done_s     = 1'b1;
          f_next_s   = 14'h0000;
          cnt_next_s = cnt_r + CNT_ONE;
        end else begin
          f_next_s   = f_r;
        end
      end
      default: begin
        f_next_s      = 14'h0000;
        remain_next_s = 4'h0;
      end
    endcase
  end

  assign op.OpReady = (state_r == IDLE);
  assign F          = f_r;
  assign Done       = done_s;
  assign Illegal    = illegal_r;
  assign Halted     = (state_r == HALT);
  assign InstrCount = cnt_r;

endmodule

// File: tb/tb_instruction_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instruction_sequencer
// Scoreboard bench: the driver pushes the expected retire / illegal event for
// every accepted opcode; a negedge monitor pops and compares whenever the DUT
// raises Done or Illegal, and checks per-cycle invariants on F.
// -----------------------------------------------------------------------------
module tb_instruction_sequencer;

  localparam int LONG_C  = 3;
  localparam int CNT_W   = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic              Clock;
  logic              Reset_n;
  logic              Resume;
  logic [13:0]       F;
  logic              Done;
  logic              Illegal;
  logic              Halted;
  logic [CNT_W-1:0]  InstrCount;

  instruction_sequencer_if op_bus ();

  instruction_sequencer #(
    .LONG_CYCLES (LONG_C),
    .CNT_WIDTH   (CNT_W)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .op         (op_bus),
    .Resume     (Resume),
    .F          (F),
    .Done       (Done),
    .Illegal    (Illegal),
    .Halted     (Halted),
    .InstrCount (InstrCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    bit          illegal;
    logic [13:0] f;
    int          len;         // 0 = halt, length depends on Resume
    int          cnt_before;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   model_cnt   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode from the opcode table
  function automatic logic [13:0] ref_f(input int code);
    int long_codes[5] = '{8, 10, 11, 12, 13};
    logic [13:0] one = 14'h0001;
    if (code < 8) return one << code;
    for (int i = 0; i < 5; i++) if (code == long_codes[i]) return one << (8 + i);
    if (code == 15) return one << 13;
    return 14'h0000;
  endfunction

  task automatic push_expect(input int code);
    exp_t e;
    e.f          = ref_f(code);
    e.illegal    = (e.f == 14'h0000);
    e.len        = (code == 15) ? 0 : ((code < 8) ? 1 : LONG_C);
    e.cnt_before = model_cnt;
    if (!e.illegal) model_cnt = (model_cnt + 1) % CNT_MOD;
    sb.push_back(e);
  endtask

  // Offer an opcode, wait (bounded) for OpReady, return just after the accepting edge
  task automatic send_op(input int code, input bit with_resume);
    int n = 0;
    op_bus.OpValid = 1'b1;
    op_bus.OpCode  = 4'(code);
    if (with_resume) Resume = 1'b1;
    @(negedge Clock);
    while (!op_bus.OpReady && n < 50) begin
      @(negedge Clock);
      n++;
    end
    if (!op_bus.OpReady) begin
      check("accept_timeout", 32'(0), 32'(1));
      op_bus.OpValid = 1'b0;
      Resume = 1'b0;
    end else begin
      push_expect(code);
      @(posedge Clock);
      #1;
      op_bus.OpValid = 1'b0;
      Resume = 1'b0;
    end
  endtask

  // Halt, keep the next opcode queued for 10 cycles, resume, let it go in
  task automatic do_halt(input int next_code, input bit resume_at_accept);
    send_op(15, resume_at_accept);
    op_bus.OpValid = 1'b1;
    op_bus.OpCode  = 4'(next_code);
    @(negedge Clock);
    check("resume_at_accept_ignored", 32'({Halted, Done}), 32'(2'b10));
    repeat (10) begin
      @(negedge Clock);
      check("halt_ready_low", 32'(op_bus.OpReady), 32'(0));
      check("halt_f", 32'(F), 32'(14'h2000));
    end
    @(posedge Clock); #1;
    Resume = 1'b1;
    @(posedge Clock); #1;
    Resume = 1'b0;
    send_op(next_code, 1'b0);
  endtask

  // Scoreboard monitor and per-cycle invariants
  logic [13:0] prev_f = 14'h0000;
  int          run_len = 0;
  bit          cnt_pending = 1'b0;
  int          cnt_expect = 0;

  always @(negedge Clock) begin
    exp_t e;
    if (!Reset_n) begin
      sb.delete();
      cnt_pending = 1'b0;
      run_len     = 0;
      prev_f      = 14'h0000;
    end else begin
      if (cnt_pending) begin
        check("count_after_retire", 32'(InstrCount), 32'(cnt_expect));
        check("idle_after_retire", 32'({F, op_bus.OpReady}), 32'({14'h0000, 1'b1}));
        cnt_pending = 1'b0;
      end
      if (F != 14'h0000 && F == prev_f) run_len++;
      else if (F != 14'h0000) run_len = 1;
      else run_len = 0;
      prev_f = F;
      check("f_onehot0", 32'($onehot0(F)), 32'(1));
      check("f_zero_when_ready", 32'(op_bus.OpReady && (F != 14'h0000)), 32'(0));
      check("halted_vs_f", 32'(Halted), 32'(F == 14'h2000));
      if (Done || Illegal) begin
        if (sb.size() == 0) begin
          check("unexpected_event", 32'({Done, Illegal}), 32'(0));
        end else begin
          e = sb.pop_front();
          if (e.illegal) begin
            check("illegal_pulse", 32'({Done, Illegal, F, op_bus.OpReady}),
                  32'({1'b0, 1'b1, 14'h0000, 1'b1}));
            check("count_hold_illegal", 32'(InstrCount), 32'(e.cnt_before));
          end else begin
            check("retire_kind", 32'({Done, Illegal}), 32'(2'b10));
            check("retire_f", 32'(F), 32'(e.f));
            check("count_before", 32'(InstrCount), 32'(e.cnt_before));
            if (e.len != 0) check("exec_length", 32'(run_len), 32'(e.len));
            cnt_pending = 1'b1;
            cnt_expect  = (e.cnt_before + 1) % CNT_MOD;
          end
        end
      end
    end
  end

  initial begin
    int n;
    int gap;
    Reset_n        = 1'b0;
    Resume         = 1'b0;
    op_bus.OpValid = 1'b0;
    op_bus.OpCode  = 4'h0;
    @(negedge Clock);
    @(negedge Clock);
    check("reset_state", 32'({F, Done, Illegal, Halted, InstrCount, op_bus.OpReady}),
          32'({14'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1}));
    #2 Reset_n = 1'b1;
    @(posedge Clock); #1;

    // directed: short, long, back-to-back illegal, halt with queued opcode
    send_op(3, 1'b0);
    @(posedge Clock); #1;
    send_op(12, 1'b0);
    send_op(9, 1'b0);
    send_op(14, 1'b0);
    do_halt(5, 1'b1);

    // reset during the first execute cycle of a long opcode
    send_op(8, 1'b0);
    Reset_n = 1'b0;
    #1;
    check("reset_mid_exec", 32'({F, Done, Halted, InstrCount, op_bus.OpReady}),
          32'({14'h0000, 1'b0, 1'b0, 4'h0, 1'b1}));
    model_cnt = 0;
    @(negedge Clock);
    #2 Reset_n = 1'b1;
    @(negedge Clock);
    check("idle_after_reset", 32'({op_bus.OpReady, F}), 32'({1'b1, 14'h0000}));
    @(posedge Clock); #1;

    // counter wrap: 17 short opcodes
    for (int i = 0; i < 17; i++) send_op(int'($urandom_range(0, 7)), 1'b0);

    // randomized mix with stray Resume pulses outside HALT
    for (int i = 0; i < 150; i++) begin
      n = int'($urandom_range(0, 15));
      if (n == 15) do_halt(int'($urandom_range(0, 14)), 1'($urandom_range(0, 1)));
      else send_op(n, 1'b0);
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin
        Resume = ($urandom_range(0, 3) == 0);
        @(posedge Clock); #1;
      end
      Resume = 1'b0;
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge Clock);
      n++;
    end
    @(negedge Clock);
    check("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

- Sequences 4-bit opcodes from an upstream fetch stage into timed, registered one-hot control enables `F[13:0]`. These enables drive the 14 datapath units.
- It uses the team's 14-way opcode decode map, accepts one instruction at a time over a valid/ready handshake, holds each enable for its execution length, and parks on the halt opcode until resumed.
- It sits between instruction fetch and the datapath, replacing direct combinational decoding.

## Interface
Parameters:
- `LONG_CYCLES`, default 2: execute cycles for long opcodes 1000, 1010, 1011, 1100, 1101. Legal range 1..15.
- `CNT_WIDTH`, default 8: width of the retired-instruction counter.

Ports:
- `Clock`  in  1  single clock, rising edge
- `Reset_n`  in  1  asynchronous, active-low reset
- `OpValid`  in  1  upstream opcode valid
- `OpCode`  in  4  opcode, sampled when `OpValid && OpReady`
- `OpReady`  out  1  sequencer can accept an opcode
- `Resume`  in  1  leave HALT
- `F`  out  14  registered one-hot datapath enables; all zero when idle
- `Done`  out  1  asserted in the final cycle of each retiring instruction
- `Illegal`  out  1  one-cycle pulse after an undefined opcode is accepted
- `Halted`  out  1  high while in HALT
- `InstrCount`  out  CNT_WIDTH  retired-instruction count, wraps

## Operation
Decode map (opcode -> F bit):
- 0000..0111 -> bits 0..7, short, 1 cycle.
- 1000 -> 8, 1010 -> 9, 1011 -> 10, 1100 -> 11, 1101 -> 12. All long, `LONG_CYCLES` cycles.
- 1111 -> 13, halt.
- 1001 and 1110 are illegal.

States: IDLE, EXEC, HALT. `OpReady` = (state == IDLE).

IDLE:
- No transfer: `F` = 0.
- Accepting a legal non-halt opcode: `F` <= its one-hot bit, `remain` <= length-1, go to EXEC.
- Accepting 1111: `F` <= bit 13, go to HALT.
- Accepting an illegal opcode: `Illegal` <= 1 for one cycle, `F` stays 0, stay in IDLE, `InstrCount` unchanged.

EXEC:
- `F` is held constant.
- If `remain` != 0: decrement it.
- If `remain` == 0: `Done` = 1 (combinational from state/remain), then at the edge `F` <= 0, `InstrCount` += 1, go to IDLE.

HALT:
- `F` = bit 13 is held and `Halted` = 1.
- `Resume` high in HALT: `Done` = 1 that cycle, then at the edge `F` <= 0, `InstrCount` += 1, go to IDLE.
- `Resume` outside HALT is ignored.

General rules:
- `F` never has more than one bit set.
- `F` is zero in IDLE, including the cycle after an illegal opcode.
- `InstrCount` wraps from 2^CNT_WIDTH-1 to 0. Illegal opcodes are never counted.
- `OpCode` is ignored when `OpValid` = 0 or `OpReady` = 0. Upstream must hold `OpCode` stable while `OpValid` is high and `OpReady` is low.

## Timing
Reset (asynchronous, `Reset_n` low):
- state = IDLE, `F` = 0, `remain` = 0, `Illegal` = 0, `InstrCount` = 0.
- `Done` = 0, `Halted` = 0, `OpReady` = 1.
- Upstream must not treat `OpReady` as a transfer while in reset.
- Reset mid-EXEC or mid-HALT aborts the instruction immediately and does not count it.

Latency and throughput:
- Accept at edge k -> `F` valid from cycle k+1.
- Short op: `F` and `Done` high in cycle k+1; IDLE in cycle k+2.
- Long op: `F` high in cycles k+1..k+LONG_CYCLES; `Done` high in cycle k+LONG_CYCLES.
- After retirement the sequencer spends one IDLE cycle before accepting again. Back-to-back short ops therefore retire one per 2 cycles.

Boundary cases:
- Illegal opcode: `Illegal` is high in cycle k+1, and `OpReady` stays 1. A new opcode may be accepted in cycle k+1.
- `Resume` asserted on the same edge as halt acceptance has no effect; the sequencer is not yet in HALT.

## Test plan
- Reset, then one short op: send 0011 with `OpValid` for one cycle -> `F` = 14'h0008 for exactly 1 cycle, `Done` high in that cycle, `InstrCount` = 1.
- Long op with `LONG_CYCLES` = 2, send 1100 -> `F` = 14'h0800 for 2 cycles, `OpReady` low for both, `Done` only in the second, `InstrCount` +1.
- Illegal ops: send 1001, then 1110 back-to-back -> `Illegal` pulses twice, `F` stays 0, `InstrCount` unchanged, `OpReady` stays 1.
- Halt: send 1111 -> `F` = 14'h2000 and `Halted` = 1, with `OpValid` held high and `OpReady` = 0 for 10 cycles. Pulse `Resume` -> `Done` that cycle, `F` = 0, IDLE next cycle, queued op accepted.
- Reset mid-EXEC: during cycle 1 of 1000 with `LONG_CYCLES` = 3, assert `Reset_n` = 0 -> `F` = 0 and `InstrCount` = 0 immediately; state is IDLE after release.
- Wrap: with `CNT_WIDTH` = 4, retire 17 short ops -> `InstrCount` reads 15 then 0 then 1; `F` is one-hot or zero every cycle (assertion).
